fp4_round_pack: RTL

Pipelined rounder/packer that consumes the wide product format produced by the FP4 multiplier stage ({sign, unbiased 3-bit exponent, {I,F,G,R,S} significand}) and re-encodes it into the packed 4-bit FP4 format {s, e[1:0], m} (bias 1). It is the return path of the multiplier interface: multiplier and accumulator results in wide form enter here and leave as storable FP4 codes. It adds round-to-nearest-even, overflow saturation, underflow clamping and exception flags, and uses a valid/ready handshake on both sides.

---
 rtl/fp4_round_pack_if.sv | 32 +++
 rtl/fp4_round_pack.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/fp4_round_pack_if.sv
// Handshake and payload bundle for the FP4 round/pack stage.
//   slave  : the rounder (consumes the wide beat, produces the packed beat)
//   master : the producer/consumer around it (drives wide beat and i_ready)
// Input side : i_valid, o_ready, i_sign, i_exp_u[2:0], i_sig_grs[4:0]
// Output side: o_valid, i_ready, o_fp4[3:0], o_inexact, o_ovf, o_unf
interface fp4_round_pack_if;
  localparam int unsigned EXP_W = 3;
  localparam int unsigned SIG_W = 5;
  localparam int unsigned FP4_W = 4;

  logic             i_valid;
  logic             o_ready;
  logic             i_sign;
  logic [EXP_W-1:0] i_exp_u;
  logic [SIG_W-1:0] i_sig_grs;
  logic             o_valid;
  logic             i_ready;
  logic [FP4_W-1:0] o_fp4;
  logic             o_inexact;
  logic             o_ovf;
  logic             o_unf;

  modport slave (
    input  i_valid, i_sign, i_exp_u, i_sig_grs, i_ready,
    output o_ready, o_valid, o_fp4, o_inexact, o_ovf, o_unf
  );

  modport master (
    output i_valid, i_sign, i_exp_u, i_sig_grs, i_ready,
    input  o_ready, o_valid, o_fp4, o_inexact, o_ovf, o_unf
  );
endinterface

// File: rtl/fp4_round_pack.sv
// Two-stage rounder/packer: wide product {sign, exp_u, I.F G R S} -> FP4 {s,e[1:0],m}
// with round-to-nearest-even, overflow saturation to +-6.0, underflow clamp to
// +-0.5 and per-beat exception flags. Valid/ready on both sides; a single
// advance enable freezes the whole pipeline while the output is stalled.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   bus (slave)         input beat i_valid/o_ready/i_sign/i_exp_u/i_sig_grs,
//                       output beat o_valid/i_ready/o_fp4/o_inexact/o_ovf/o_unf
//   i_cnt_clr           counter clear            (FP4_RP_STATS_EN only)
//   o_cnt_inexact/ovf/unf  saturating event counters (FP4_RP_STATS_EN only)
// Build option: define FP4_RP_STATS_EN to add the statistics counters.
module fp4_round_pack
`ifdef FP4_RP_STATS_EN
  #(parameter int unsigned CNT_W = 16)
`endif
(
  input  logic            i_clk,
  input  logic            i_rst,
  fp4_round_pack_if.slave bus
`ifdef FP4_RP_STATS_EN
  ,
  input  logic             i_cnt_clr,
  output logic [CNT_W-1:0] o_cnt_inexact,
  output logic [CNT_W-1:0] o_cnt_ovf,
  output logic [CNT_W-1:0] o_cnt_unf
`endif
);

  localparam int unsigned EXP_W = 4;
  localparam int unsigned FP4_W = 4;

  // Stage 1 (rounded) and stage 2 (packed) registers
  logic                    s1_v_q;
  logic                    s1_sign_q;
  logic signed [EXP_W-1:0] s1_exp_q, s1_exp_d;
  logic                    s1_f_q, s1_f_d;
  logic                    s1_inx_q, s1_inx_d;
  logic                    o_valid_q;
  logic [FP4_W-1:0]        o_fp4_q, o_fp4_d;
  logic                    o_inexact_q, o_inexact_d;
  logic                    o_ovf_q, o_ovf_d;
  logic                    o_unf_q, o_unf_d;

  logic en_c;
  logic f_c, g_c, r_c, s_c;
  logic rnd_up_c;
  logic unused_c;
  logic signed [EXP_W-1:0] exp_ext_c;
  logic [1:0] e_c;

  // Global advance: the pipeline moves whenever the output slot is free or drained
  assign en_c        = ~o_valid_q | bus.i_ready;
  assign bus.o_ready = en_c;

  // The leading bit is implied to be 1 and carries no information
  assign unused_c = bus.i_sig_grs[4];

  // Round to nearest even on the 1-bit fraction; a carry out of I.F bumps the exponent
  always_comb begin
    f_c       = bus.i_sig_grs[3];
    g_c       = bus.i_sig_grs[2];
    r_c       = bus.i_sig_grs[1];
    s_c       = bus.i_sig_grs[0];
    rnd_up_c  = g_c & (r_c | s_c | f_c);
    exp_ext_c = {bus.i_exp_u[2], bus.i_exp_u};
    s1_exp_d  = exp_ext_c + EXP_W'(rnd_up_c & f_c);
    s1_f_d    = f_c ^ rnd_up_c;
    s1_inx_d  = g_c | r_c | s_c;
  end

  // Pack into bias-1 FP4, saturating or clamping out-of-range exponents
  always_comb begin
    e_c         = 2'(s1_exp_q + 4'sd1);
    o_fp4_d     = {s1_sign_q, e_c, s1_f_q};
    o_inexact_d = s1_inx_q;
    o_ovf_d     = 1'b0;
    o_unf_d     = 1'b0;
    if (s1_exp_q > 4'sd2) begin
      o_fp4_d     = {s1_sign_q, 3'b111};
      o_inexact_d = 1'b1;
      o_ovf_d     = 1'b1;
    end else if (s1_exp_q < -4'sd1) begin
      o_fp4_d     = {s1_sign_q, 3'b000};
      o_inexact_d = 1'b1;
      o_unf_d     = 1'b1;
    end
  end

  // Pipeline registers; data loads on every advance, valid bits ride alongside
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_v_q      <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_exp_q    <= '0;
      s1_f_q      <= 1'b0;
      s1_inx_q    <= 1'b0;
      o_valid_q   <= 1'b0;
      o_fp4_q     <= '0;
      o_inexact_q <= 1'b0;
      o_ovf_q     <= 1'b0;
      o_unf_q     <= 1'b0;
    end else if (en_c) begin
      s1_v_q      <= bus.i_valid;
      s1_sign_q   <= bus.i_sign;
      s1_exp_q    <= s1_exp_d;
      s1_f_q      <= s1_f_d;
      s1_inx_q    <= s1_inx_d;
      o_valid_q   <= s1_v_q;
      o_fp4_q     <= o_fp4_d;
      o_inexact_q <= o_inexact_d;
      o_ovf_q     <= o_ovf_d;
      o_unf_q     <= o_unf_d;
    end
  end

  assign bus.o_valid   = o_valid_q;
  assign bus.o_fp4     = o_fp4_q;
  assign bus.o_inexact = o_inexact_q;
  assign bus.o_ovf     = o_ovf_q;
  assign bus.o_unf     = o_unf_q;

`ifdef FP4_RP_STATS_EN
  logic hs_c;
  assign hs_c = o_valid_q & bus.i_ready;

  // Saturating flag counters, bumped once per delivered beat; clear has priority
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_cnt_inexact <= '0;
      o_cnt_ovf     <= '0;
      o_cnt_unf     <= '0;
    end else if (i_cnt_clr) begin
      o_cnt_inexact <= '0;
      o_cnt_ovf     <= '0;
      o_cnt_unf     <= '0;
    end else begin
      if (hs_c & o_inexact_q & ~&o_cnt_inexact) o_cnt_inexact <= o_cnt_inexact + CNT_W'(1);
      if (hs_c & o_ovf_q & ~&o_cnt_ovf)         o_cnt_ovf     <= o_cnt_ovf + CNT_W'(1);
      if (hs_c & o_unf_q & ~&o_cnt_unf)         o_cnt_unf     <= o_cnt_unf + CNT_W'(1);
    end
  end
`endif

endmodule
